// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: DEPTH-stage valid/ready register chain with bubble collapse, flush and occupancy count
module elastic_pipe_reg #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  occupancy
);
    logic [DEPTH-1:0]      valid_q, valid_d, ready;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [CNT_WIDTH-1:0]  occ_q, occ_d;
    logic                  in_xfer, out_xfer;

    // in_ready is a combinational function of out_ready so the chain sustains one item per cycle;
    // this long path is deliberate and must be covered by timing constraints
    assign in_ready  = ready[0] & ~flush & ~rst;
    assign out_valid = valid_q[DEPTH-1] & ~rst;
    assign out_data  = rst ? '0 : data_q[DEPTH-1];
    assign occupancy = rst ? '0 : occ_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign occ_d     = occ_q + CNT_WIDTH'(in_xfer) - CNT_WIDTH'(out_xfer);

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        // a stage can take new contents when it, or any stage between it and the output, has room
        assign ready[g] = ~(&valid_q[DEPTH-1:g]) | out_ready;
        if (g == 0) begin : g_head
            assign valid_d[g] = ready[g] ? in_xfer : valid_q[g];
            assign data_d[g]  = ready[g] ? in_data : data_q[g];
        end else begin : g_body
            assign valid_d[g] = ready[g] ? valid_q[g-1] : valid_q[g];
            assign data_d[g]  = ready[g] ? data_q[g-1] : data_q[g];
        end
    end

    // advance the chain; reset clears everything, flush only drops the valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '{default: '0};
            occ_q   <= '0;
        end else if (flush) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            occ_q   <= occ_d;
        end
    end
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb_elastic_pipe_reg: directed stimulus with queue scoreboards for a DEPTH=4 and a DEPTH=1 chain
module tb_elastic_pipe_reg;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [15:0] in_data;
    logic        in_ready0, out_valid0;
    logic [15:0] out_data0;
    logic [2:0]  occ0;
    logic        in_ready1, out_valid1;
    logic [7:0]  out_data1;
    logic [0:0]  occ1;
    logic [15:0] q0[$];
    logic [7:0]  q1[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    elastic_pipe_reg #(.DATA_WIDTH(16), .DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .occupancy(occ0)
    );

    elastic_pipe_reg #(.DATA_WIDTH(8), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data[7:0]),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor pops on every output transfer, then the queue mirrors accepts and discards
    always @(negedge clk) begin
        if (out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb0_unexpected: got 0x%0h expected no item", out_data0);
            end else chk("sb0_data", out_data0, q0.pop_front());
        end
        if (out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb1_unexpected: got 0x%0h expected no item", out_data1);
            end else chk("sb1_data", out_data1, q1.pop_front());
        end
        if (rst || flush) begin
            q0.delete();
            q1.delete();
        end else begin
            if (in_valid && in_ready0) q0.push_back(in_data);
            if (in_valid && in_ready1) q1.push_back(in_data[7:0]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d);
        in_valid = v;
        in_data  = d;
    endtask

    task automatic fill(input int n, input logic [15:0] base);
        int acc = 0;
        int budget = 20;
        while (acc < n && budget > 0) begin
            drive(1'b1, 16'(base + acc));
            #1;
            if (in_ready0) acc++;
            cyc();
            budget--;
        end
        drive(1'b0, 16'h0);
        chk("fill_count", acc, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        cyc(); cyc();
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_data", out_data0, 0);
        chk("rst_occ", occ0, 0);
        chk("rst_in_ready", in_ready0, 0);
        chk("rst_d1_out_valid", out_valid1, 0);
        rst = 1'b0;

        out_ready = 1'b1;
        drive(1'b1, 16'h00A1);
        cyc();
        drive(1'b0, 16'h0);
        chk("t1_occ_e0", occ0, 1);
        chk("t1_ov_e0", out_valid0, 0);
        chk("t1_d1_ov_e0", out_valid1, 1);
        chk("t1_d1_data_e0", out_data1, 8'hA1);
        chk("t1_d1_occ_e0", occ1, 1);
        cyc();
        chk("t1_occ_e1", occ0, 1);
        chk("t1_ov_e1", out_valid0, 0);
        chk("t1_d1_ov_e1", out_valid1, 0);
        chk("t1_d1_occ_e1", occ1, 0);
        cyc();
        chk("t1_occ_e2", occ0, 1);
        chk("t1_ov_e2", out_valid0, 0);
        cyc();
        chk("t1_ov_e3", out_valid0, 1);
        chk("t1_data_e3", out_data0, 16'h00A1);
        chk("t1_occ_e3", occ0, 1);
        cyc();
        chk("t1_ov_e4", out_valid0, 0);
        chk("t1_occ_e4", occ0, 0);

        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 16'(i));
            #1;
            chk("t2_in_ready", in_ready0, 1);
            cyc();
        end
        drive(1'b0, 16'h0);
        chk("t2_ov_tail", out_valid0, 1);
        chk("t2_data_tail", out_data0, 13);
        chk("t2_occ_tail", occ0, 4);
        for (int j = 1; j <= 3; j++) begin
            cyc();
            chk("t2_drain_data", out_data0, 13 + j);
            chk("t2_drain_occ", occ0, 4 - j);
        end
        cyc();
        chk("t2_empty_ov", out_valid0, 0);
        chk("t2_empty_occ", occ0, 0);

        out_ready = 1'b0;
        acc = 0;
        for (int n = 0; n < 6; n++) begin
            drive(1'b1, 16'(16'h0021 + acc));
            #1;
            if (in_ready0) acc++;
            cyc();
        end
        chk("t3_accepts", acc, 4);
        chk("t3_in_ready_full", in_ready0, 0);
        chk("t3_occ_full", occ0, 4);
        chk("t3_ov_full", out_valid0, 1);
        chk("t3_data_held", out_data0, 16'h0021);
        drive(1'b0, 16'h0);
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("t3_drain_data", out_data0, 16'h0021 + k);
            chk("t3_drain_occ", occ0, 4 - k);
        end
        cyc();
        chk("t3_empty_occ", occ0, 0);
        chk("t3_empty_ov", out_valid0, 0);

        out_ready = 1'b0;
        fill(4, 16'h0031);
        chk("t4_occ_full", occ0, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'(16'h0035 + i));
            #1;
            chk("t4_in_ready", in_ready0, 1);
            cyc();
            chk("t4_occ", occ0, 4);
        end
        drive(1'b0, 16'h0);
        repeat (4) cyc();
        chk("t4_empty_occ", occ0, 0);

        out_ready = 1'b0;
        fill(3, 16'h0041);
        chk("t5_occ3", occ0, 3);
        flush = 1'b1;
        drive(1'b1, 16'h0044);
        #1;
        chk("t5_in_ready_flush", in_ready0, 0);
        cyc();
        flush = 1'b0;
        drive(1'b0, 16'h0);
        chk("t5_occ", occ0, 0);
        chk("t5_ov", out_valid0, 0);
        out_ready = 1'b1;
        repeat (6) begin
            cyc();
            chk("t5_no_out", out_valid0, 0);
        end

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(16'h0051 + i));
            cyc();
        end
        rst = 1'b1;
        drive(1'b1, 16'h0054);
        #1;
        chk("t6_in_ready_rst", in_ready0, 0);
        cyc();
        rst = 1'b0;
        drive(1'b0, 16'h0);
        #1;
        chk("t6_ov", out_valid0, 0);
        chk("t6_data", out_data0, 0);
        chk("t6_occ", occ0, 0);
        chk("t6_d1_ov", out_valid1, 0);
        chk("t6_d1_data", out_data1, 0);
        drive(1'b1, 16'h0BEE);
        cyc();
        drive(1'b0, 16'h0);
        chk("t6_ov_e0", out_valid0, 0);
        cyc();
        chk("t6_ov_e1", out_valid0, 0);
        cyc();
        chk("t6_ov_e2", out_valid0, 0);
        cyc();
        chk("t6_ov_e3", out_valid0, 1);
        chk("t6_data_e3", out_data0, 16'h0BEE);
        cyc();
        chk("t6_ov_e4", out_valid0, 0);
        chk("t6_occ_e4", occ0, 0);

        repeat (3) cyc();
        chk("sb0_left", q0.size(), 0);
        chk("sb1_left", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
- Parametrised successor to the plain D flip-flop primitives: a chain of DEPTH data registers with per-stage valid bits and valid/ready backpressure.
- Empty stages (bubbles) collapse, so the chain holds up to DEPTH items.
- Used between datapath units (conv/pool/FC) for timing slack and rate decoupling.
- Adds a synchronous flush and an occupancy count.

Parameters:
- DATA_WIDTH, 16, width of each data item.
- DEPTH, 4, number of register stages; must be at least 1.
- CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all stored items.
- in_valid  input  1  upstream item present.
- in_ready  output  1  block can accept an item this cycle.
- in_data  input  DATA_WIDTH  upstream item.
- out_valid  output  1  stage DEPTH-1 holds an item.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_WIDTH  item held in stage DEPTH-1.
- occupancy  output  CNT_WIDTH  number of valid stages (0..DEPTH).

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst, sampled on the rising edge of clk.
  - When rst is high at an edge, all stage valid bits, all data registers and occupancy become 0 after that edge.
  - Outputs while in reset: out_valid=0, out_data=0, occupancy=0. in_ready is 0 while rst is high.
- Stage state: stage i (i=0..DEPTH-1) holds data_i and valid_i. Stage 0 is the input side; stage DEPTH-1 drives out_data and out_valid.
- Ready chain (combinational):
  - ready_(DEPTH-1) = ~valid_(DEPTH-1) | out_ready.
  - ready_i = ~valid_i | ready_(i+1).
  - in_ready = ready_0 & ~flush & ~rst.
  - Full-throughput path: in_ready depends combinationally on out_ready. This is intentional and is documented for timing.
- Stage update on each edge (no rst, no flush):
  - Stage i with ready_i loads data and valid from stage i-1.
  - Stage 0 loads in_data and in_valid&in_ready.
  - A stage that is not ready holds its contents.
  - A stage whose item moves on and which receives nothing becomes invalid. Its data register may keep the stale value, but out_data is only meaningful while out_valid=1.
- Transfers: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Latency: an item accepted at edge t is visible on out_valid/out_data after edge t+DEPTH-1, provided no stall occurs ahead of it.
- Throughput: one item per cycle sustained while out_ready=1.
- Bubble collapse: when out_ready=0, items advance into empty downstream stages until the chain is full.
- Full: all valid_i=1 and out_ready=0 → in_ready=0. The chain holds and no data is lost or overwritten.
- Full with out_ready=1: in_ready=1. Simultaneous push and pop leaves occupancy unchanged at DEPTH.
- Empty: out_valid=0. An item entering an empty chain still takes DEPTH edges to reach the output; there is no bypass.
- Flush:
  - flush high at an edge clears all valid bits; occupancy=0 after the edge.
  - in_ready is 0 during the flush cycle, so no input is accepted.
  - out_valid in the flush cycle reflects the current state. If out_ready=1 in that cycle, the item counts as consumed; flush wins anyway.
- rst has priority over flush.
- occupancy: registered.
  - occupancy_next = occupancy + in_xfer - out_xfer.
  - Forced to 0 on rst or flush.
  - Must always equal the popcount of the valid bits.
- Data is never reordered, duplicated or dropped outside of flush and rst.
- Reset mid-operation: all in-flight items are discarded. The next accepted item behaves as if the chain were empty.

Test Plan:
- DEPTH=4, out_ready=1. Push 0x00A1 at edge 0. Expected: out_valid=1 with out_data=0x00A1 after edge 3, and occupancy goes 1,1,1,1 then 0 after the pop at edge 4.
- Stream 0x0001..0x0010 with in_valid and out_ready held at 1. Expected: outputs in order, one per cycle after the 3-edge fill, in_ready constantly 1.
- out_ready=0, push continuously. Expected: exactly 4 accepts, in_ready falls to 0 once occupancy=4, and out_data stays at the first item. Then raise out_ready. Expected: 4 items drained in order, no loss.
- Full chain, out_ready=1 and in_valid=1 for 10 cycles. Expected: occupancy stays at 4 and the order is preserved.
- 3 items in flight, assert flush for 1 cycle with in_valid=1. Expected: in_ready=0 that cycle, occupancy=0 and out_valid=0 after the edge, and the flushed items never appear.
- Mid-stream, assert rst for 1 cycle. Expected: all outputs 0 after the edge. Then push 0x0BEE. Expected: it emerges after 4 cycles. Also rerun the stream test with DEPTH=1, DATA_WIDTH=8 to confirm parametrisation.
